// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state encoding and the decoded control bundle for the
// multi-cycle MIPS32 main control unit.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } cause_e;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic [2:0] alu_ctrl;
        logic       is_lw;
        logic       is_sw;
        logic       is_beq;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational decode of the latched instruction word into the control bundle.
// Illegal encodings yield an all-zero bundle with only the illegal flag set.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] ir_i,
    output ctrl_t       ctl_o
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_ir;

    assign op        = ir_i[31:26];
    assign funct     = ir_i[5:0];
    assign unused_ir = ^ir_i[25:6];

    always_comb begin
        ctl_o = '0;
        case (op)
            OP_RTYPE: begin
                ctl_o.reg_dst = 1'b1;
                case (funct)
                    FN_ADD:  ctl_o.alu_ctrl = ALU_ADD;
                    FN_SUB:  ctl_o.alu_ctrl = ALU_SUB;
                    FN_AND:  ctl_o.alu_ctrl = ALU_AND;
                    FN_OR:   ctl_o.alu_ctrl = ALU_OR;
                    FN_SLT:  ctl_o.alu_ctrl = ALU_SLT;
                    default: ctl_o.illegal  = 1'b1;
                endcase
            end
            OP_LW: begin
                ctl_o.alu_src    = 1'b1;
                ctl_o.mem_to_reg = 1'b1;
                ctl_o.alu_ctrl   = ALU_ADD;
                ctl_o.is_lw      = 1'b1;
            end
            OP_SW: begin
                ctl_o.alu_src  = 1'b1;
                ctl_o.alu_ctrl = ALU_ADD;
                ctl_o.is_sw    = 1'b1;
            end
            OP_BEQ: begin
                ctl_o.alu_ctrl = ALU_SUB;
                ctl_o.is_beq   = 1'b1;
            end
            OP_ADDI: begin
                ctl_o.alu_src  = 1'b1;
                ctl_o.alu_ctrl = ALU_ADD;
            end
            default: ctl_o.illegal = 1'b1;
        endcase
        if (ctl_o.illegal) begin
            ctl_o         = '0;
            ctl_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle main control FSM: sequences datapath strobes, watches the data
// memory handshake, counts retired instructions and traps on faults.
//
//   state    | meaning
//   FETCH    | latch Instruction into ir
//   DECODE   | register mux selects, reject illegal encodings
//   EXEC     | ALU cycle; beq resolves and advances PC here
//   MEM      | MemRead/MemWrite held until mem_ready or watchdog expiry
//   WB       | RegWrite with PC advance
//   TRAP     | all strobes off until reset
module mips_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instruction,
    input  logic             mem_ready,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic [2:0]       ALUControl,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             Branch,
    output logic             pc_en,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MEM_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [31:0]        ir_q, ir_d;
    ctrl_t              ctl_q, ctl_d, dec;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    cause_e             cause_q, cause_d;
    logic [CNT_W-1:0]   retired_q;
    logic               unused_ctl;

    mips_ctrl_decode u_decode (
        .ir_i  (ir_q),
        .ctl_o (dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            ctl_q     <= '0;
            tmr_q     <= '0;
            cause_q   <= CAUSE_NONE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctl_q   <= ctl_d;
            tmr_q   <= tmr_d;
            cause_q <= cause_d;
            if (pc_en) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        ctl_d    = ctl_q;
        tmr_d    = tmr_q;
        cause_d  = cause_q;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        Branch   = 1'b0;
        pc_en    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = Instruction;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ctl_d = dec;
                if (dec.illegal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ctl_q.is_beq) begin
                    Branch  = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                end else if (ctl_q.is_lw || ctl_q.is_sw) begin
                    tmr_d   = TMR_LOAD;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                MemRead  = ctl_q.is_lw;
                MemWrite = ctl_q.is_sw;
                // A ready in the final watchdog cycle still completes the access.
                if (mem_ready) begin
                    if (ctl_q.is_sw) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmr_q == '0) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                pc_en    = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    assign RegDst     = ctl_q.reg_dst;
    assign ALUSrc     = ctl_q.alu_src;
    assign MemtoReg   = ctl_q.mem_to_reg;
    assign ALUControl = ctl_q.alu_ctrl;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign retired    = retired_q;
    assign unused_ctl = ctl_q.illegal;

endmodule
